// File: rtl/systolic_ctrl.sv
// Sequencer for a DIM x DIM systolic array: optional accumulator clear, operand feed, skew flush.
// Define SYSTOLIC_READBACK_EN to add a READ phase that walks c_row over the accumulators after FLUSH.
module systolic_ctrl #(
    parameter int DIM   = 4,
    parameter int CNT_W = $clog2(2*DIM-1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_c,
    input  logic             stall,
    output logic             en,
    output logic             WrEn,
    output logic [CNT_W-1:0] c_row,
    output logic             c_zero,
    output logic             feed_valid,
    output logic [CNT_W-1:0] feed_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_DIM   = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(2*DIM - 3);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign busy = (state != S_IDLE);

    // Stall only gates the strobes; the index outputs keep pointing at the frozen position.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        en         = 1'b0;
        WrEn       = 1'b0;
        c_row      = '0;
        c_zero     = 1'b0;
        feed_valid = 1'b0;
        feed_idx   = '0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = clr_c ? S_CLEAR : S_FEED;
                    cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                c_row = cnt;
                if (!stall) begin
                    WrEn   = 1'b1;
                    c_zero = 1'b1;
                    if (cnt == LAST_DIM) begin
                        state_nx = S_FEED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            S_FEED: begin
                feed_idx = cnt;
                if (!stall) begin
                    en         = 1'b1;
                    feed_valid = 1'b1;
                    if (cnt == LAST_DIM) begin
                        state_nx = S_FLUSH;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    en = 1'b1;
                    if (cnt == LAST_FLUSH) begin
`ifdef SYSTOLIC_READBACK_EN
                        state_nx = S_READ;
`else
                        state_nx = S_DONE;
`endif
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SYSTOLIC_READBACK_EN
            S_READ: begin
                c_row = cnt;
                if (!stall) begin
                    if (cnt == LAST_DIM) begin
                        state_nx = S_DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
`endif
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule
